// File: rtl/counter_seq_ctrl.sv
// Sequencer and round-robin load arbiter for a shared loadable MINV..MAXV counter.
// Drives the counter enable from a prescaler while running and flags counter wrap.
module counter_seq_ctrl #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned W        = 4,
  parameter int unsigned PRESCALE = 10,
  parameter int unsigned MINV     = 1,
  parameter int unsigned MAXV     = 12
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_req_d,
  input  logic [W-1:0]      i_cnt_q,
  output logic [NREQ-1:0]   o_gnt,
  output logic              o_cnt_en,
  output logic              o_cnt_load,
  output logic [W-1:0]      o_cnt_d,
  output logic              o_running,
  output logic              o_wrap,
  output logic              o_err
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [W-1:0]      LP_MINV     = W'(MINV);
  localparam logic [W-1:0]      LP_MAXV     = W'(MAXV);
  localparam logic [SW-1:0]     LP_PRE_LAST = SW'(PRESCALE - 1);
  localparam logic [PW-1:0]     LP_LAST_REQ = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StLoad
  } state_e;

  state_e          r_state;
  logic [SW-1:0]   r_pre;
  logic [PW-1:0]   r_rr;
  logic            r_saved_run;

  logic            w_any_req;
  logic            w_win_found;
  logic [PW-1:0]   w_win_idx;
  logic [W-1:0]    w_win_val;
  logic            w_val_ok;
  logic [PW-1:0]   w_rr_next;
  logic [NREQ-1:0] w_gnt_oh;
  logic            w_pre_last;
  logic            w_do_grant;

  // Round-robin search: first asserted request at or after the rr pointer wins.
  always_comb begin
    int v_idx;
    w_any_req   = |i_req;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    v_idx       = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      v_idx = (int'(r_rr) + k) % int'(NREQ);
      if (!w_win_found && i_req[v_idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = PW'(v_idx);
      end
    end
    w_win_val  = i_req_d[int'(w_win_idx)*int'(W) +: W];
    w_val_ok   = (w_win_val >= LP_MINV) && (w_win_val <= LP_MAXV);
    w_rr_next  = (w_win_idx == LP_LAST_REQ) ? '0 : w_win_idx + PW'(1);
    w_gnt_oh   = NREQ'(1) << w_win_idx;
    w_pre_last = (r_pre == LP_PRE_LAST);
    // stop outranks a request in RUN; the request stays pending for IDLE
    w_do_grant = w_win_found &&
                 ((r_state == StIdle) || ((r_state == StRun) && !i_stop));
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_pre       <= '0;
      r_rr        <= '0;
      r_saved_run <= 1'b0;
      o_gnt       <= '0;
      o_cnt_en    <= 1'b0;
      o_cnt_load  <= 1'b0;
      o_cnt_d     <= '0;
      o_running   <= 1'b0;
      o_wrap      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_gnt      <= '0;
      o_cnt_en   <= 1'b0;
      o_cnt_load <= 1'b0;
      o_wrap     <= 1'b0;
      o_err      <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state     <= StLoad;
            r_saved_run <= 1'b0;
            o_running   <= 1'b0;
          end else if (i_start && !i_stop) begin
            r_state   <= StRun;
            r_pre     <= '0;
            o_running <= 1'b1;
          end
        end
        StRun: begin
          if (i_stop) begin
            r_state   <= StIdle;
            r_pre     <= '0;
            o_running <= 1'b0;
          end else if (w_any_req) begin
            r_state     <= StLoad;
            r_saved_run <= 1'b1;
          end else if (w_pre_last) begin
            r_pre    <= '0;
            o_cnt_en <= 1'b1;
            o_wrap   <= (i_cnt_q == LP_MAXV);
          end else begin
            r_pre <= r_pre + SW'(1);
          end
        end
        StLoad: begin
          if (i_stop || !r_saved_run) begin
            r_state   <= StIdle;
            r_pre     <= '0;
            o_running <= 1'b0;
          end else begin
            r_state   <= StRun;
            o_running <= 1'b1;
          end
          r_saved_run <= 1'b0;
        end
        default: begin
          r_state   <= StIdle;
          r_pre     <= '0;
          o_running <= 1'b0;
        end
      endcase

      // An out-of-range value still consumes the request but leaves cnt_d alone.
      if (w_do_grant) begin
        o_gnt <= w_gnt_oh;
        r_rr  <= w_rr_next;
        if (w_val_ok) begin
          o_cnt_load <= 1'b1;
          o_cnt_d    <= w_win_val;
        end else begin
          o_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed self-checking bench for counter_seq_ctrl: prescaler, wrap, loads, arbitration, stop.
module tb_counter_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic [1:0] req;
  logic [7:0] req_d;
  logic [3:0] cnt_q;
  logic [1:0] gnt;
  logic       cnt_en;
  logic       cnt_load;
  logic [3:0] cnt_d;
  logic       running;
  logic       wrap;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  counter_seq_ctrl #(
    .NREQ    (2),
    .W       (4),
    .PRESCALE(10),
    .MINV    (1),
    .MAXV    (12)
  ) u_dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_stop    (stop),
    .i_req     (req),
    .i_req_d   (req_d),
    .i_cnt_q   (cnt_q),
    .o_gnt     (gnt),
    .o_cnt_en  (cnt_en),
    .o_cnt_load(cnt_load),
    .o_cnt_d   (cnt_d),
    .o_running (running),
    .o_wrap    (wrap),
    .o_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector layout: {gnt[1:0], load, cnt_d[3:0], en, wrap, err, running}
  function automatic logic [10:0] obs();
    return {gnt, cnt_load, cnt_d, cnt_en, wrap, err, running};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; stop = 1'b0; req = 2'b00; req_d = 8'h00; cnt_q = 4'd5;
    repeat (3) step();
    n_cmp++;
    if (obs() !== 11'b00_0_0000_0_0_0_0) begin
      n_bad++;
      $display("FAIL reset: got %b want %b", obs(), 11'b0);
    end
    reset = 1'b1;
    step();  // enters RUN
    n_cmp++;
    if (obs() !== {2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL run_entry: got %b want running only", obs());
    end
  endtask

  task automatic test_prescale();
    for (int i = 1; i <= 25; i++) begin
      step();
      n_cmp++;
      if (obs() !== {2'b00, 1'b0, 4'd0, (i % 10 == 0), 1'b0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL prescale cyc %0d: got %b want en=%0d", i, obs(), (i % 10 == 0));
      end
    end
  endtask

  task automatic test_wrap();
    cnt_q = 4'd12;
    for (int i = 26; i <= 30; i++) begin
      step();
      n_cmp++;
      if (obs() !== {2'b00, 1'b0, 4'd0, (i == 30), (i == 30), 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL wrap12 cyc %0d: got %b want en/wrap=%0d", i, obs(), (i == 30));
      end
    end
    cnt_q = 4'd11;
    for (int i = 31; i <= 40; i++) begin
      step();
      n_cmp++;
      if (obs() !== {2'b00, 1'b0, 4'd0, (i == 40), 1'b0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL wrap11 cyc %0d: got %b want en=%0d wrap=0", i, obs(), (i == 40));
      end
    end
  endtask

  task automatic test_load();
    repeat (3) step();  // prescaler now 3
    req = 2'b01; req_d = {4'd5, 4'd9};
    step();
    n_cmp++;
    if (obs() !== {2'b01, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL load9: got %b want gnt=01 load=1 d=9 running", obs());
    end
    req = 2'b00;
    // prescaler held at 3 across the request and LOAD cycles: 7 more RUN edges to enable
    for (int i = 1; i <= 8; i++) begin
      step();
      n_cmp++;
      if (obs() !== {2'b00, 1'b0, 4'd9, (i == 8), 1'b0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL load_resume cyc %0d: got %b want en=%0d", i, obs(), (i == 8));
      end
    end
  endtask

  task automatic test_bad_value();
    logic [3:0] bad_vals [2];
    bad_vals[0] = 4'd0;
    bad_vals[1] = 4'd13;
    for (int k = 0; k < 2; k++) begin
      req = 2'b10; req_d = {bad_vals[k], 4'd3};
      step();
      n_cmp++;
      if (obs() !== {2'b10, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1}) begin
        n_bad++;
        $display("FAIL bad_val %0d: got %b want gnt=10 err=1 d=9", bad_vals[k], obs());
      end
      req = 2'b00;
      step();
      n_cmp++;
      if (obs() !== {2'b00, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL bad_val_after %0d: got %b want quiet running", bad_vals[k], obs());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_seq [5];
    exp_seq[0] = {2'b01, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_seq[1] = {2'b00, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_seq[2] = {2'b10, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_seq[3] = {2'b00, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_seq[4] = {2'b01, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    req = 2'b11; req_d = {4'd5, 4'd3};
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (obs() !== exp_seq[i]) begin
        n_bad++;
        $display("FAIL b2b step %0d: got %b want %b", i, obs(), exp_seq[i]);
      end
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_stop_and_req();
    stop = 1'b1; start = 1'b0; req = 2'b01; req_d = {4'd5, 4'd7};
    step();
    n_cmp++;
    if (obs() !== {2'b00, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL stop_req idle: got %b want all quiet, running=0", obs());
    end
    step();
    n_cmp++;
    if (obs() !== {2'b01, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL stop_req load: got %b want gnt=01 load=1 d=7 running=0", obs());
    end
    req = 2'b00; stop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++;
      if (obs() !== {2'b00, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL stop_req idle_hold %0d: got %b want quiet idle", i, obs());
      end
    end
    // start together with stop: stop wins, remain idle
    start = 1'b1; stop = 1'b1;
    step();
    step();
    n_cmp++;
    if (running !== 1'b0) begin
      n_bad++;
      $display("FAIL start_stop: running got %b want 0", running);
    end
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_wrap();
    test_load();
    test_bad_value();
    test_back_to_back();
    test_stop_and_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
